// File: rtl/conv_out_streamer.sv
// Serialises the conv engine's flat result bus onto a valid/ready stream, one word per beat,
// tagging each word with its feature-map channel, row and column.
module conv_out_streamer #(
  parameter int unsigned N            = 16,
  parameter int unsigned IMG_SIZE     = 8,
  parameter int unsigned K            = 3,
  parameter int unsigned OUT_CHANNELS = 4,
  parameter int unsigned OUT_SIDE     = IMG_SIZE - K + 1,
  parameter int unsigned TOTAL        = OUT_CHANNELS * OUT_SIDE * OUT_SIDE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 conv_done,
  input  logic [N*TOTAL-1:0]   out_mem_flat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N-1:0]         m_data,
  output logic [7:0]           m_channel,
  output logic [7:0]           m_row,
  output logic [7:0]           m_col,
  output logic                 m_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned IdxW = $clog2(TOTAL) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TOTAL - 1);
  localparam logic [7:0] SideMax = 8'(OUT_SIDE - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e               state_q, state_d;
  logic                 done_prev_q;
  logic [N*TOTAL-1:0]   shadow_q, shadow_d;
  logic [N*TOTAL-1:0]   shadow_shift;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [7:0]           f_q, f_d;
  logic [7:0]           oy_q, oy_d;
  logic [7:0]           ox_q, ox_d;
  logic [N-1:0]         data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 fd_q, fd_d;
  logic                 ovr_q, ovr_d;
  logic                 start_evt;
  logic                 accept;

  assign start_evt    = conv_done & ~done_prev_q;
  assign accept       = valid_q & m_ready;
  // The shadow shifts down one word per beat, so the next element is always in the low bits.
  assign shadow_shift = shadow_q >> N;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    f_d      = f_q;
    oy_d     = oy_q;
    ox_d     = ox_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    fd_d     = 1'b0;
    ovr_d    = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (start_evt) begin
          state_d  = StStream;
          shadow_d = out_mem_flat;
          data_d   = out_mem_flat[N-1:0];
          idx_d    = '0;
          f_d      = '0;
          oy_d     = '0;
          ox_d     = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          last_d   = (TOTAL == 1);
        end
      end
      StStream: begin
        if (start_evt) begin
          ovr_d = 1'b1;
        end
        if (accept) begin
          if (last_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            fd_d    = 1'b1;
          end else begin
            shadow_d = shadow_shift;
            data_d   = shadow_shift[N-1:0];
            idx_d    = idx_q + IdxW'(1);
            last_d   = (idx_d == LastIdx);
            if (ox_q == SideMax) begin
              ox_d = '0;
              if (oy_q == SideMax) begin
                oy_d = '0;
                f_d  = f_q + 8'd1;
              end else begin
                oy_d = oy_q + 8'd1;
              end
            end else begin
              ox_d = ox_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      done_prev_q <= 1'b0;
      shadow_q    <= '0;
      idx_q       <= '0;
      f_q         <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= conv_done;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      f_q         <= f_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      fd_q        <= fd_d;
      ovr_q       <= ovr_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_channel  = f_q;
  assign m_row      = oy_q;
  assign m_col      = ox_q;
  assign m_last     = last_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Bench for conv_out_streamer: a queue-based frame model checked every cycle, plus directed
// scenarios with literal expectations for stream ordering, stalls, overrun and reset.
module tb_conv_out_streamer;

  localparam int unsigned N     = 16;
  localparam int unsigned SIDE  = 6;
  localparam int unsigned TOTAL = 4 * SIDE * SIDE;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
    logic [7:0]  r;
    logic [7:0]  x;
    logic        l;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               conv_done = 1'b0;
  logic [N*TOTAL-1:0] mem = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [N-1:0]       m_data;
  logic [7:0]         m_channel, m_row, m_col;
  logic               m_last, busy, frame_done, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  conv_out_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .conv_done    (conv_done),
    .out_mem_flat (mem),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_channel    (m_channel),
    .m_row        (m_row),
    .m_col        (m_col),
    .m_last       (m_last),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame model: a start event while idle enqueues the whole captured frame.
  beat_t exp_q[$];
  bit    mdl_active = 0;
  bit    mdl_fd = 0;
  bit    mdl_ovr = 0;
  bit    mdl_prev = 0;

  beat_t got[512];
  int    n_got = 0;
  int    fd_cnt = 0;
  bit    prev_stall = 0;
  beat_t prev_out;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_data", m_data, 0);
      exp_q.delete();
      mdl_active = 0;
      mdl_fd = 0;
      mdl_ovr = 0;
      mdl_prev = 0;
      prev_stall = 0;
    end else begin
      bit start, was;
      chk("valid", m_valid, mdl_active);
      chk("busy", busy, mdl_active);
      chk("frame_done", frame_done, mdl_fd);
      chk("overrun", overrun, mdl_ovr);
      if (frame_done) fd_cnt++;
      if (mdl_active && m_valid) begin
        chk("data", m_data, exp_q[0].d);
        chk("channel", m_channel, exp_q[0].c);
        chk("row", m_row, exp_q[0].r);
        chk("col", m_col, exp_q[0].x);
        chk("last", m_last, exp_q[0].l);
      end
      if (prev_stall) begin
        chk("stall_hold", {m_data, m_channel, m_row, m_col, m_last}, prev_out);
      end
      prev_stall = m_valid && !m_ready;
      prev_out = '{d: m_data, c: m_channel, r: m_row, x: m_col, l: m_last};
      if (m_valid && m_ready && n_got < 512) begin
        got[n_got] = prev_out;
        n_got++;
      end
      start = conv_done && !mdl_prev;
      mdl_prev = conv_done;
      was = mdl_active;
      mdl_fd = 0;
      if (mdl_active && m_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          mdl_active = 0;
          mdl_fd = 1;
        end
      end
      if (start) begin
        if (was) mdl_ovr = 1;
        else begin
          for (int i = 0; i < TOTAL; i++) begin
            exp_q.push_back('{d: mem[i*N +: N], c: 8'(i / (SIDE * SIDE)),
                              r: 8'((i / SIDE) % SIDE), x: 8'(i % SIDE), l: (i == TOTAL - 1)});
          end
          mdl_active = 1;
        end
      end
    end
  end

  // Ready pattern: always high, or pseudo-random with a 5-cycle stall on beat 35.
  bit ready_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!ready_mode) m_ready = 1'b1;
    else if (n_got == 35 && stall_cnt < 5) begin
      m_ready = 1'b0;
      stall_cnt++;
    end else m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_got = 0;
    fd_cnt = 0;
  endtask

  task automatic pulse_done();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step();
      if (frame_done) break;
    end
    if (k == budget) chk("frame_done_timeout", 0, 1);
    else chk("busy_falls_with_done", busy, 0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    for (k = 0; k < budget && n_got < target; k++) step();
    if (n_got < target) chk("beat_wait_timeout", n_got, target);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < TOTAL; i++) mem[i*N +: N] = 16'(i + 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_channel", m_channel, 0);

    // Scenario 1: ramp frame, continuous ready
    fill_ramp();
    step();
    clear_stats();
    conv_done = 1'b1;
    #1 chk("valid_before_edge", m_valid, 0);
    step();
    conv_done = 1'b0;
    chk("valid_after_edge", m_valid, 1);
    wait_fd(400);
    repeat (3) step();
    chk("s1_beats", n_got, TOTAL);
    chk("s1_fd_count", fd_cnt, 1);
    chk("beat0", got[0], {16'd1, 8'd0, 8'd0, 8'd0, 1'b0});
    chk("beat6", got[6], {16'd7, 8'd0, 8'd1, 8'd0, 1'b0});
    chk("beat36", got[36], {16'd37, 8'd1, 8'd0, 8'd0, 1'b0});
    chk("beat143", got[143], {16'd144, 8'd3, 8'd5, 8'd5, 1'b1});

    // Scenario 2: same frame under random backpressure
    clear_stats();
    stall_cnt = 0;
    ready_mode = 1;
    pulse_done();
    wait_fd(3000);
    ready_mode = 0;
    repeat (3) step();
    chk("s2_beats", n_got, TOTAL);
    chk("s2_stall_seen", stall_cnt, 5);
    for (int i = 0; i < TOTAL; i++) chk("s2_seq", got[i].d, 16'(i + 1));

    // Scenario 3: conv_done held high for 300 cycles gives exactly one frame
    clear_stats();
    conv_done = 1'b1;
    repeat (300) step();
    conv_done = 1'b0;
    chk("s3_beats", n_got, TOTAL);
    chk("s3_fd_count", fd_cnt, 1);
    chk("s3_overrun", overrun, 0);
    step();
    clear_stats();
    pulse_done();
    wait_fd(400);
    step();
    chk("s3_second_frame", n_got, TOTAL);

    // Scenario 4: negative patterns survive a bus change after capture
    clear_stats();
    for (int i = 0; i < TOTAL; i++) mem[i*N +: N] = (i % 2 == 0) ? 16'h8001 : 16'hFFFF;
    pulse_done();
    for (int i = 0; i < TOTAL; i++) mem[i*N +: N] = 16'h1234;
    wait_fd(400);
    step();
    chk("s4_beat0", got[0].d, 16'h8001);
    chk("s4_beat1", got[1].d, 16'hFFFF);
    chk("s4_beat143", got[143].d, 16'hFFFF);

    // Scenario 5: overrun at beat 50, then a clean restart
    fill_ramp();
    clear_stats();
    pulse_done();
    wait_beats(50, 200);
    pulse_done();
    step();
    chk("s5_overrun_set", overrun, 1);
    wait_fd(400);
    step();
    chk("s5_beats", n_got, TOTAL);
    chk("s5_fd_count", fd_cnt, 1);
    clear_stats();
    pulse_done();
    wait_fd(400);
    step();
    chk("s5_restart_beats", n_got, TOTAL);
    chk("s5_overrun_sticky", overrun, 1);

    // Scenario 6: reset mid-frame at beat 70
    clear_stats();
    pulse_done();
    wait_beats(70, 200);
    reset = 1'b1;
    #1;
    chk("s6_async_valid", m_valid, 0);
    chk("s6_async_busy", busy, 0);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("s6_no_frame_done", fd_cnt, 0);
    clear_stats();
    pulse_done();
    chk("s6_restart", {m_valid, m_data, m_channel, m_row, m_col, overrun},
        {1'b1, 16'd1, 8'd0, 8'd0, 8'd0, 1'b0});
    wait_fd(400);
    step();
    chk("s6_beats", n_got, TOTAL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
- Drains the parallel result bus of the convolution engine after each `done`.
- Captures `out_mem_flat` into a shadow register on the rising edge of `done`.
- Serialises the captured elements one word per handshake on a valid/ready stream, tagging each with channel/row/col, so pooling/FC stages or a host DMA consume results without a wide bus.
- Sits directly downstream of `conv`, on its output side, mirroring how the flat input buses are packed.

Parameters:
- N, 16, word width (signed fixed-point, passed through untouched)
- IMG_SIZE, 8, input image side of the upstream conv
- K, 3, kernel side of the upstream conv
- OUT_CHANNELS, 4, number of output feature maps
- OUT_SIDE, IMG_SIZE-K+1, derived output side (6)
- TOTAL, OUT_CHANNELS*OUT_SIDE*OUT_SIDE, derived element count (144)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- conv_done  in  1  done from conv (level, may stay high)
- out_mem_flat  in  N*TOTAL  conv result bus; element i at bits [i*N +: N]
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  N  current element
- m_channel  out  8  feature-map index f of current element
- m_row  out  8  oy of current element
- m_col  out  8  ox of current element
- m_last  out  1  high with final element (index TOTAL-1)
- busy  out  1  high from capture until last beat accepted
- frame_done  out  1  one-cycle pulse after last beat accepted
- overrun  out  1  sticky: conv_done rose while busy

Behaviour:
- Reset, asynchronous:
  - State becomes IDLE immediately.
  - m_valid, m_last, busy, frame_done, overrun = 0.
  - m_data, m_channel, m_row, m_col = 0.
  - Element index = 0; shadow register = 0; done_prev = 0.
  - Reset mid-stream abandons the frame with no frame_done.
- Edge detect: done_prev <= conv_done every cycle. start_evt = conv_done & ~done_prev.
  - If conv_done is already high when reset deasserts, one frame starts at the first edge.
- FSM states: IDLE, STREAM.
- IDLE:
  - On edge E with start_evt: shadow <= out_mem_flat; index <= 0; state <= STREAM; busy <= 1.
  - Outputs present element 0 from edge E, so m_valid is high one cycle after conv_done is first sampled high.
- STREAM:
  - m_data = shadow[index*N +: N].
  - m_channel = index / (OUT_SIDE*OUT_SIDE); m_row = (index / OUT_SIDE) % OUT_SIDE; m_col = index % OUT_SIDE.
  - Counters are kept as nested f/oy/ox counters, not dividers.
  - m_last = (index == TOTAL-1).
  - All outputs are registered and held stable while m_valid & ~m_ready.
  - Handshake is m_valid & m_ready at an edge. One word per cycle is sustained under continuous m_ready, with no bubbles.
  - Handshake on a non-last word: index increments; ox wraps OUT_SIDE-1→0 with oy++; oy wraps with f++.
  - Handshake on the last word: state <= IDLE; m_valid, m_last, busy <= 0; frame_done = 1 for exactly the next cycle.
- Overrun: start_evt while in STREAM (including the cycle of the last handshake):
  - Event is ignored and overrun <= 1 (sticky until reset).
  - Shadow is not reloaded and the current frame is unaffected.
  - The next frame requires a fresh rising edge of conv_done.
- Immediate restart: start_evt in the first IDLE cycle (the frame_done cycle) starts a new frame normally.
- Timing and data handling:
  - Total frame time under continuous m_ready is TOTAL cycles from the first m_valid.
  - No arithmetic is performed on data; bits pass through unchanged, sign included.
  - out_mem_flat may change after capture without affecting the stream.
- m_ready is ignored while m_valid = 0.

Test Plan:
- Reset, then drive element i = i+1, m_ready=1, pulse conv_done one cycle → m_valid rises the edge after the pulse. 144 consecutive beats with data 1..144. Beat 0 is ch0,r0,c0; beat 6 is ch0,r1,c0; beat 36 is ch1,r0,c0; beat 143 is ch3,r5,c5 with m_last=1. frame_done pulses once; busy falls with it.
- Same frame, with m_ready toggling in a pseudo-random pattern and held low for 5 cycles on beat 35 → m_data/m_channel/m_row/m_col remain stable while stalled. The 144-word sequence is identical to the first scenario, with no drops or duplicates.
- Hold conv_done high for 300 cycles → exactly one frame of 144 beats, overrun stays 0. Lower then raise conv_done → second frame starts.
- Load elements with 0x8001 and 0xFFFF patterns, then change out_mem_flat to all 0x1234 one cycle after capture → the stream still carries the original values bit-exact, including negatives.
- Raise a new conv_done edge at beat 50 → overrun=1 and the frame continues to beat 143 unaffected. Re-raise conv_done after frame_done → a new frame streams and overrun stays 1.
- Assert reset at beat 70 → m_valid/busy drop to 0 asynchronously with no frame_done. After release plus a conv_done edge, the stream restarts at element 0 (ch0,r0,c0) with overrun=0.
